// File: rtl/mux_lut2_pkg.sv
// mux_lut2_pkg -- shared types and helpers for the mux-only 2-input LUT with
// built-in self-test.
//   op_t      : gate opcode as presented on cfg_op
//   state_t   : self-test controller states
//   op_to_tt  : opcode -> 4-bit truth table indexed by {b,a}
//   op_eval   : operator-level reference result used by the self-test compare
package mux_lut2_pkg;

  typedef enum logic [2:0] {
    OP_BUF_A = 3'd0,
    OP_INV_A = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_NAND  = 3'd5,
    OP_NOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_RESET = 4'b1010;  // BUF_A

  function automatic logic [3:0] op_to_tt(op_t op);
    logic [3:0] tt;
    case (op)
      OP_BUF_A: tt = 4'b1010;
      OP_INV_A: tt = 4'b0101;
      OP_AND:   tt = 4'b1000;
      OP_OR:    tt = 4'b1110;
      OP_XOR:   tt = 4'b0110;
      OP_NAND:  tt = 4'b0111;
      OP_NOR:   tt = 4'b0001;
      OP_XNOR:  tt = 4'b1001;
      default:  tt = TT_RESET;
    endcase
    return tt;
  endfunction

  // Deliberately written with logic operators rather than a table lookup so the
  // self-test compares the mux tree against an independent formulation.
  function automatic logic op_eval(op_t op, logic a, logic b);
    logic r;
    case (op)
      OP_BUF_A: r = a;
      OP_INV_A: r = ~a;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux_lut2_bist_mux2x1.sv
// mux2x1 -- single 2:1 mux cell, the only primitive used by the LUT tree.
//   d0, d1 : data inputs
//   sel    : select (1 picks d1)
//   y      : selected data
module mux2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_lut2_bist.sv
// mux_lut2_bist -- 2-input gate built from a registered truth table and a tree
// of three 2:1 muxes, with a 4-vector self-test run after each configuration
// or on request.
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_vld/cfg_op  : configuration request and opcode; cfg_rdy gates accept
//   rerun           : repeat the self-test with the current configuration
//   a, b / y        : functional operands and result (y forced 0 while busy)
//   busy/done/pass  : self-test status; err_vec flags failing {b,a} vectors
//   fault_en        : only when MUX_LUT2_FAULT_INJECT_EN is defined; inverts
//                     tt[3] at the tree input during the self-test
//
// state | meaning
// IDLE  | no test run since reset, functional path active
// RUN   | stepping vec 0..3 through the tree, cfg/rerun ignored
// DONE  | result held on done/pass/err_vec, functional path active
module mux_lut2_bist
  import mux_lut2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_vld,
  input  logic [2:0] cfg_op,
  output logic       cfg_rdy,
  input  logic       rerun,
  input  logic       a,
  input  logic       b,
`ifdef MUX_LUT2_FAULT_INJECT_EN
  input  logic       fault_en,
`endif
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec
);

  state_t     state_q, state_d;
  op_t        op_q, op_d;
  logic [3:0] tt_q, tt_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] err_q, err_d;
  logic       pass_q, pass_d;

  logic start_cfg, start_rerun;
  logic sel_a, sel_b, tt3_eff;
  logic m0, m1, tree_y, mismatch;

  // cfg_vld wins over rerun; both are dead while cfg_rdy is low.
  assign start_cfg   = cfg_vld && cfg_rdy;
  assign start_rerun = rerun && cfg_rdy && !cfg_vld;

  assign sel_a = busy ? vec_q[0] : a;
  assign sel_b = busy ? vec_q[1] : b;

`ifdef MUX_LUT2_FAULT_INJECT_EN
  assign tt3_eff = tt_q[3] ^ (fault_en & busy);
`else
  assign tt3_eff = tt_q[3];
`endif

  mux2x1 u_mux_lo (.d0(tt_q[0]), .d1(tt_q[1]), .sel(sel_a), .y(m0));
  mux2x1 u_mux_hi (.d0(tt_q[2]), .d1(tt3_eff), .sel(sel_a), .y(m1));
  mux2x1 u_mux_out (.d0(m0), .d1(m1), .sel(sel_b), .y(tree_y));

  assign mismatch = tree_y != op_eval(op_q, vec_q[0], vec_q[1]);

  assign y       = tree_y & ~busy;
  assign pass    = pass_q;
  assign err_vec = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_cfg || start_rerun) state_d = ST_RUN;
      ST_RUN:           if (vec_q == 2'd3) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    cfg_rdy = (state_q != ST_RUN);
  end

  always_comb begin
    op_d   = op_q;
    tt_d   = tt_q;
    vec_d  = vec_q;
    err_d  = err_q;
    pass_d = pass_q;
    if (start_cfg) begin
      op_d   = op_t'(cfg_op);
      tt_d   = op_to_tt(op_t'(cfg_op));
      vec_d  = 2'd0;
      err_d  = 4'b0000;
      pass_d = 1'b0;
    end else if (start_rerun) begin
      vec_d  = 2'd0;
      err_d  = 4'b0000;
      pass_d = 1'b0;
    end else if (busy) begin
      err_d[vec_q] = err_q[vec_q] | mismatch;
      vec_d        = vec_q + 2'd1;
      if (vec_q == 2'd3) pass_d = ~|err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_BUF_A;
      tt_q   <= TT_RESET;
      vec_q  <= 2'd0;
      err_q  <= 4'b0000;
      pass_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      tt_q   <= tt_d;
      vec_q  <= vec_d;
      err_q  <= err_d;
      pass_q <= pass_d;
    end
  end

endmodule
